// File: rtl/serial_operand_serializer_msb_first_if.sv
// Handshake and serial-output bundle for serial_operand_serializer_msb_first.
// The slave modport is the serializer; the master modport is the operand
// producer that also observes the serial bit lines.
interface serial_operand_serializer_msb_first_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         a;
    logic         b;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, out_valid, out_first, out_last, a, b
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, out_valid, out_first, out_last, a, b
    );
endinterface

// File: rtl/serial_operand_serializer_msb_first.sv
// Operand-pair serializer: accepts W-bit operands over valid/ready and shifts
// them out one bit per clock on a/b with first/last frame markers.
// Default order is MSB first; defining SERIAL_SERIALIZER_LSB_FIRST_EN
// reverses the shift direction (LSB first) with identical handshake/timing.
module serial_operand_serializer_msb_first #(
    parameter int unsigned W = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    serial_operand_serializer_msb_first_if.slave  bus
);
    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [W-1:0]  sh_a, sh_a_next;
    logic [W-1:0]  sh_b, sh_b_next;

    logic          tap_a, tap_b;
    logic [W-1:0]  sh_a_shifted, sh_b_shifted;
    logic          cnt_at_last;
    logic          ready;
    logic          accept;

`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
    assign tap_a        = sh_a[0];
    assign tap_b        = sh_b[0];
    assign sh_a_shifted = {1'b0, sh_a[W-1:1]};
    assign sh_b_shifted = {1'b0, sh_b[W-1:1]};
`else
    assign tap_a        = sh_a[W-1];
    assign tap_b        = sh_b[W-1];
    assign sh_a_shifted = {sh_a[W-2:0], 1'b0};
    assign sh_b_shifted = {sh_b[W-2:0], 1'b0};
`endif

    assign cnt_at_last = (cnt == CNT_LAST);
    assign ready       = ~rst & ((state == IDLE) | ((state == SHIFT) & cnt_at_last));
    assign accept      = bus.in_valid & ready;
    assign bus.in_ready = ready;

    // State, counter and shift registers; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sh_a  <= sh_a_next;
            sh_b  <= sh_b_next;
        end
    end

    // Next-state logic and serial outputs; outputs are zero outside a frame.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        sh_a_next     = sh_a;
        sh_b_next     = sh_b;
        bus.out_valid = 1'b0;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;
        bus.a         = 1'b0;
        bus.b         = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    sh_a_next  = bus.in_a;
                    sh_b_next  = bus.in_b;
                end
            end
            SHIFT: begin
                bus.out_valid = 1'b1;
                bus.out_first = (cnt == '0);
                bus.out_last  = cnt_at_last;
                bus.a         = tap_a;
                bus.b         = tap_b;
                if (cnt_at_last) begin
                    // Reload on the final bit gives back-to-back frames with no gap.
                    cnt_next = '0;
                    if (accept) begin
                        sh_a_next = bus.in_a;
                        sh_b_next = bus.in_b;
                    end else begin
                        state_next = IDLE;
                        sh_a_next  = sh_a_shifted;
                        sh_b_next  = sh_b_shifted;
                    end
                end else begin
                    cnt_next  = cnt + 1'b1;
                    sh_a_next = sh_a_shifted;
                    sh_b_next = sh_b_shifted;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule
